// File: rtl/iob_intr_pkt_arbiter.sv
// Round-robin arbiter that turns IOB interrupt requests into 2-flit NoC packets (header, payload).
// Optional starvation monitor enabled by defining IOB_ARB_STARVE_CHK_EN.
module iob_intr_pkt_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int X_TILES = 2,
   parameter int NUM_TILES = 4,
   parameter logic [3:0] NOC_FBITS_L1 = 4'b0010,
   parameter logic [7:0] MSG_TYPE_INTERRUPT = 8'd33,
   localparam int NOC_DATA_WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_val,
   output logic [NUM_REQ-1:0]          req_rdy,
   input  logic [32*NUM_REQ-1:0]       req_tileid,
   input  logic [64*NUM_REQ-1:0]       req_payload,
   output logic                        noc_out_val,
   input  logic                        noc_out_rdy,
   output logic [NOC_DATA_WIDTH-1:0]   noc_out_data,
   output logic                        busy,
   output logic                        err_bad_tile
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int NOC_X_WIDTH = 8;
   localparam int NOC_Y_WIDTH = 8;
   localparam logic [63:0] PAY_CLEAR_MASK = 64'h0000_0000_0000_FE00;

   typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

   state_t            state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [63:0]       hdr_q, pay_q;

   logic              win_found;
   logic [PTR_W-1:0]  win_idx;
   int                idx;
   logic [31:0]       sel_tile;
   logic [63:0]       sel_payload;
   logic              tile_ok;
   logic              can_grant;

   function automatic logic [63:0] make_header(input logic [31:0] tile);
      logic [63:0] h;
      h = '0;
      h[49:42] = NOC_X_WIDTH'(tile % 32'(X_TILES));
      h[41:34] = NOC_Y_WIDTH'(tile / 32'(X_TILES));
      h[33:30] = NOC_FBITS_L1;
      h[29:22] = 8'd1;
      h[21:14] = MSG_TYPE_INTERRUPT;
      return h;
   endfunction

   // Cyclic search for the first asserted request at or after rr_ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_found && req_val[idx]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(idx);
         end
      end
   end

   assign sel_tile    = req_tileid[32*int'(win_idx) +: 32];
   assign sel_payload = req_payload[64*int'(win_idx) +: 64];
   assign tile_ok     = (sel_tile < 32'(NUM_TILES));

   // A new packet can start from IDLE, or from BODY as its last flit leaves.
   assign can_grant = rst_n && win_found &&
                      ((state_q == IDLE) || ((state_q == BODY) && noc_out_rdy));

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      req_rdy      = '0;
      err_bad_tile = 1'b0;
      noc_out_val  = 1'b0;
      noc_out_data = '0;
      busy         = (state_q != IDLE);

      if (can_grant) begin
         req_rdy      = NUM_REQ'(1) << win_idx;
         err_bad_tile = !tile_ok;
         rr_ptr_d     = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (can_grant && tile_ok) state_d = HDR;
         end
         HDR: begin
            noc_out_val  = 1'b1;
            noc_out_data = hdr_q;
            if (noc_out_rdy) state_d = BODY;
         end
         BODY: begin
            noc_out_val  = 1'b1;
            noc_out_data = pay_q;
            if (noc_out_rdy) state_d = (can_grant && tile_ok) ? HDR : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         hdr_q    <= '0;
         pay_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         if (can_grant && tile_ok) begin
            hdr_q <= make_header(sel_tile);
            pay_q <= sel_payload & ~PAY_CLEAR_MASK;
         end
      end
   end

`ifdef IOB_ARB_STARVE_CHK_EN
   logic [15:0] wait_cnt [NUM_REQ];

   // Saturating per-requester wait counters; report once on reaching the limit.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!rst_n || !req_val[i] || req_rdy[i]) begin
            wait_cnt[i] <= '0;
         end else if (wait_cnt[i] != 16'hFFFF) begin
            wait_cnt[i] <= wait_cnt[i] + 16'd1;
            if (wait_cnt[i] == 16'hFFFE) begin
               $display("%d : Simulation -> FAIL(iob_intr_pkt_arbiter starvation req %0d)", $time, i);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_iob_intr_pkt_arbiter.sv
// Randomized bench for iob_intr_pkt_arbiter with a packet-level reference model.
module tb_iob_intr_pkt_arbiter;

   localparam int NREQ = 4;
   localparam int XT = 2;
   localparam int NT = 4;
   localparam logic [63:0] FBITS_L1 = 64'd2;
   localparam logic [63:0] TYPE_INTR = 64'd33;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req_val;
   logic [3:0]    req_rdy;
   logic [127:0]  req_tileid;
   logic [255:0]  req_payload;
   logic          noc_out_val;
   logic          noc_out_rdy;
   logic [63:0]   noc_out_data;
   logic          busy;
   logic          err_bad_tile;

   int tests_run = 0;
   int tests_failed = 0;

   // Model and stimulus state
   logic [63:0] flit_q[$];
   logic [63:0] obs[$];
   int          grant_log[$];
   int          grant_cyc[$];
   int          rr = 0;
   int          cyc = 0;
   bit [3:0]    pend = '0;
   bit          rearm = 0;
   bit          rdy_drv = 1;
   bit          rst_drv = 0;
   logic [31:0] tile_a [NREQ];
   logic [63:0] pay_a [NREQ];

   iob_intr_pkt_arbiter #(.NUM_REQ(NREQ), .X_TILES(XT), .NUM_TILES(NT)) dut (
      .clk(clk), .rst_n(rst_n), .req_val(req_val), .req_rdy(req_rdy),
      .req_tileid(req_tileid), .req_payload(req_payload),
      .noc_out_val(noc_out_val), .noc_out_rdy(noc_out_rdy), .noc_out_data(noc_out_data),
      .busy(busy), .err_bad_tile(err_bad_tile)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mk_hdr(input logic [31:0] t);
      logic [63:0] x, y;
      x = 64'(t % XT) % 256;
      y = 64'(t / XT) % 256;
      return (x << 42) + (y << 34) + (FBITS_L1 << 30) + (64'd1 << 22) + (TYPE_INTR << 14);
   endfunction

   function automatic logic [63:0] mk_pay(input logic [63:0] p);
      return ((p >> 16) << 16) + (p % 64'd512);
   endfunction

   // One clock cycle: drive, check at the falling edge, advance the model.
   task automatic applyStimulus();
      bit hs, fr, ee;
      int g, idx;
      logic [3:0] er;
      rst_n = rst_drv;
      noc_out_rdy = rdy_drv;
      for (int i = 0; i < NREQ; i++) begin
         req_val[i] = pend[i];
         req_tileid[32*i +: 32] = tile_a[i];
         req_payload[64*i +: 64] = pay_a[i];
      end
      @(negedge clk);
      checkOutput("noc_out_val", {63'd0, noc_out_val}, {63'd0, flit_q.size() > 0});
      if (flit_q.size() > 0) checkOutput("noc_out_data", noc_out_data, flit_q[0]);
      checkOutput("busy", {63'd0, busy}, {63'd0, flit_q.size() > 0});
      if (noc_out_val && noc_out_rdy) obs.push_back(noc_out_data);
      hs = (flit_q.size() > 0) && rdy_drv;
      fr = rst_drv && ((flit_q.size() == 0) || (flit_q.size() == 1 && hs));
      g = -1;
      if (fr) begin
         for (int k = 0; k < NREQ; k++) begin
            idx = (rr + k) % NREQ;
            if (g < 0 && pend[idx]) g = idx;
         end
      end
      er = (g >= 0) ? 4'(1 << g) : 4'd0;
      ee = (g >= 0) && (tile_a[g] >= NT);
      checkOutput("req_rdy", {60'd0, req_rdy}, {60'd0, er});
      checkOutput("err_bad_tile", {63'd0, err_bad_tile}, {63'd0, ee});
      if (!rst_drv) begin
         flit_q.delete();
         rr = 0;
      end else begin
         if (hs) void'(flit_q.pop_front());
         if (g >= 0) begin
            rr = (g + 1) % NREQ;
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
            if (!ee) begin
               flit_q.push_back(mk_hdr(tile_a[g]));
               flit_q.push_back(mk_pay(pay_a[g]));
            end
            if (!rearm) pend[g] = 1'b0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         tile_a[i] = 32'(i);
         pay_a[i] = 64'(i) * 64'h1111;
      end
      rst_drv = 0;
      rdy_drv = 1;
      repeat (3) applyStimulus();
      checkOutput("reset_data", noc_out_data, 64'd0);
      checkOutput("reset_rdy", {60'd0, req_rdy}, 64'd0);

      // Single request with known header/payload
      rst_drv = 1;
      obs.delete(); grant_log.delete();
      tile_a[0] = 32'd3;
      pay_a[0] = 64'h0123_4567_89AB_CDEF;
      pend[0] = 1'b1;
      repeat (5) applyStimulus();
      checkOutput("single_flits", 64'(obs.size()), 64'd2);
      checkOutput("single_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);
      if (obs.size() >= 2) begin
         checkOutput("single_hdr", obs[0], 64'h0000_0404_8048_4000);
         checkOutput("single_pay", obs[1], 64'h0123_4567_89AB_01EF);
      end

      // Continuous requests from all four, round-robin from pointer 0
      rst_drv = 0; applyStimulus(); rst_drv = 1;
      for (int i = 0; i < NREQ; i++) tile_a[i] = 32'(i);
      grant_log.delete(); grant_cyc.delete();
      pend = 4'hF; rearm = 1;
      repeat (10) applyStimulus();
      rearm = 0; pend = '0;
      repeat (4) applyStimulus();
      checkOutput("rr_count", 64'(grant_log.size()), 64'd5);
      if (grant_log.size() >= 5) begin
         for (int k = 0; k < 5; k++) begin
            checkOutput("rr_order", 64'(grant_log[k]), 64'(k % NREQ));
            if (k > 0) checkOutput("rr_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd2);
         end
      end

      // Backpressure in HDR and in BODY
      obs.delete(); grant_log.delete();
      tile_a[1] = 32'd2; pend[1] = 1'b1; rdy_drv = 1;
      applyStimulus();
      rdy_drv = 0; repeat (5) applyStimulus();
      rdy_drv = 1; applyStimulus();
      rdy_drv = 0; repeat (5) applyStimulus();
      rdy_drv = 1; repeat (3) applyStimulus();
      checkOutput("bp_flits", 64'(obs.size()), 64'd2);
      checkOutput("bp_grants", 64'(grant_log.size()), 64'd1);

      // Illegal tile id, then confirm pointer moved past it
      rst_drv = 0; applyStimulus(); rst_drv = 1;
      grant_log.delete(); obs.delete();
      tile_a[2] = 32'd7; pend[2] = 1'b1;
      applyStimulus();
      checkOutput("bad_busy", {63'd0, busy}, 64'd0);
      checkOutput("bad_val", {63'd0, noc_out_val}, 64'd0);
      tile_a[0] = 32'd1; tile_a[3] = 32'd2; pend[0] = 1'b1; pend[3] = 1'b1;
      repeat (6) applyStimulus();
      checkOutput("bad_grants", 64'(grant_log.size()), 64'd3);
      if (grant_log.size() >= 3) begin
         checkOutput("bad_g0", 64'(grant_log[0]), 64'd2);
         checkOutput("bad_g1", 64'(grant_log[1]), 64'd3);
      end
      repeat (3) applyStimulus();

      // Reset while the payload flit is stalled
      tile_a[1] = 32'd1; pend[1] = 1'b1; rdy_drv = 1;
      repeat (2) applyStimulus();
      rdy_drv = 0;
      tile_a[0] = 32'd2; tile_a[3] = 32'd3; pend[0] = 1'b1; pend[3] = 1'b1;
      rst_drv = 0; applyStimulus(); rst_drv = 1;
      checkOutput("mid_rst_val", {63'd0, noc_out_val}, 64'd0);
      checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
      grant_log.delete(); rdy_drv = 1;
      repeat (8) applyStimulus();
      checkOutput("mid_rst_g0", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         rdy_drv = ($urandom_range(0, 9) < 7);
         rst_drv = ($urandom_range(0, 299) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               tile_a[i] = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4, 40)) : 32'($urandom_range(0, 3));
               pay_a[i] = {$urandom, $urandom};
               pend[i] = 1'b1;
            end else if (pend[i] && $urandom_range(0, 49) == 0) begin
               pend[i] = 1'b0;
            end
         end
         applyStimulus();
      end
      rst_drv = 1; rdy_drv = 1; pend = '0;
      repeat (4) applyStimulus();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
